im_fetch_ctrl: RTL and testbench
================================

Name: im_fetch_ctrl

Overview:
Instruction-fetch sequencer for the 8-bit processor's instruction memory (IM).
- Owns the program counter and drives the IM address bus.
- Waits a fixed number of clocks for IM's asynchronous read delay, then captures the instruction byte.
- Presents the byte to the decode stage over a valid/ready handshake.
- Handles sequential increment, taken branches, asynchronous redirects and halt.

Parameters:
IM_ADDR_W_m1, 7, address width minus one (IM depth 256).
IM_DATA_W_m1, 7, instruction width minus one.
WAIT_CYCLES, 2, clock edges to hold ABUS stable before sampling IM_DATA; must satisfy WAIT_CYCLES*Tclk >= IM delay (10). Legal range 1..15.
RESET_PC, 8'h00, PC and ABUS value after reset.

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  synchronous active-low reset
ABUS  output  8  address to IM
IM_DATA  input  8  IM read data
INSTR  output  8  captured instruction
INSTR_PC  output  8  address INSTR was fetched from
INSTR_VALID  output  1  INSTR/INSTR_PC valid
INSTR_READY  input  1  decode consumes INSTR this cycle
BR_TAKEN  input  1  qualifies consume: next PC = BR_TARGET
BR_TARGET  input  8  branch target
REDIRECT  input  1  abort any fetch, restart at REDIRECT_PC
REDIRECT_PC  input  8  redirect address
HALT_REQ  input  1  qualifies consume: stop fetching
HALTED  output  1  fetch stopped

Behaviour:
- One clock (CLK) and a synchronous, active-low reset (RST_N) sampled on the rising edge of CLK. No asynchronous logic.
- Reset values:
  - PC=ABUS=INSTR_PC=RESET_PC; INSTR=0; INSTR_VALID=0; HALTED=0.
  - cnt=WAIT_CYCLES; state=FETCH.
  - Reset mid-fetch or mid-hold discards everything.
- States: FETCH, VALID, HALT. Encoding is held in the package.
- FETCH:
  - ABUS is held at PC.
  - If cnt!=0, decrement cnt.
  - If cnt==0: INSTR<=IM_DATA, INSTR_PC<=PC, INSTR_VALID<=1, go to VALID.
  - Latency: INSTR_VALID rises WAIT_CYCLES+1 edges after FETCH entry (3 edges with defaults).
- VALID:
  - INSTR, INSTR_PC and INSTR_VALID are held stable until consumed.
  - Consume occurs when INSTR_VALID && INSTR_READY.
  - Consume with HALT_REQ=1: HALTED<=1, INSTR_VALID<=0, go to HALT. ABUS and PC are unchanged.
  - Consume with HALT_REQ=0:
    - next = BR_TAKEN ? BR_TARGET : PC+1, mod 256 (8'hFF wraps to 8'h00).
    - PC<=next, ABUS<=next, cnt<=WAIT_CYCLES, INSTR_VALID<=0, go to FETCH.
  - HALT_REQ has priority over BR_TAKEN.
  - BR_TAKEN and HALT_REQ are ignored when not consuming.
- HALT: all outputs are frozen. Only RST_N exits this state.
- REDIRECT, valid in FETCH and VALID; ignored in HALT:
  - Highest priority, above consume, branch and halt.
  - PC<=REDIRECT_PC, ABUS<=REDIRECT_PC, cnt<=WAIT_CYCLES, INSTR_VALID<=0, go to FETCH.
  - Any in-flight fetch or held instruction is dropped.
  - REDIRECT held high for several cycles restarts the fetch each cycle. The fetch completes WAIT_CYCLES+1 edges after the last asserted edge.
- Throughput: one instruction per WAIT_CYCLES+2 clocks when READY is always high. ABUS changes only on FETCH entry, so IM sees a stable address for the whole wait.
- No combinational path from any input to any output. All outputs are registered.

Decomposition:
- Package im_ctrl_pkg:
  - IM_ADDR_W, IM_DATA_W.
  - Fetch-state enum/localparams FETCH/VALID/HALT.
  - Wait-counter width (4 bits).
- One natural sub-module: im_wait_timer. It is a loadable down-counter with load and zero flag, reused later by the data-memory controller.
- Everything else is inline in im_fetch_ctrl.

Test Plan:
1. Reset, then IM preloaded with ram[0..3]=8'h11,22,33,44, READY=1 constant → INSTR_VALID pulses with INSTR 11,22,33,44 and INSTR_PC 0,1,2,3. Each pulse comes 4 clocks after the previous; the first comes 3 edges after reset release.
2. READY=0 for 10 cycles after the first valid → INSTR=8'h11 and INSTR_PC=0 stay stable, and ABUS stays 0. With READY=1, the next fetch starts from address 1.
3. Consume at PC=8'h05 with BR_TAKEN=1, BR_TARGET=8'hFE, then sequential → INSTR_PC sequence 05, FE, FF, 00 (wrap).
4. REDIRECT=1, REDIRECT_PC=8'h40 one cycle into FETCH, and also while VALID with READY=1 and BR_TAKEN=1 → no INSTR_VALID for the aborted fetch. The next valid has INSTR_PC=8'h40; the branch is ignored.
5. Consume with HALT_REQ=1 and BR_TAKEN=1 → HALTED=1 next edge, INSTR_VALID=0. ABUS is frozen for 20 cycles despite REDIRECT pulses. RST_N low for one edge → HALTED=0, ABUS=RESET_PC.
6. Reset asserted while VALID and on the cycle cnt reaches 0 → no capture. All outputs take reset values on that edge.

Source files
------------

// File: rtl/im_ctrl_pkg.sv
// Shared types and constants for the instruction/data memory controllers.
package im_ctrl_pkg;

  localparam int IM_ADDR_W = 8;
  localparam int IM_DATA_W = 8;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    VALID = 2'b01,
    HALT  = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/im_fetch_ctrl_if.sv
// IM address/data bus plus the decode-side valid/ready handshake.
interface im_fetch_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 8
);

  logic [AW-1:0] ABUS;
  logic [DW-1:0] IM_DATA;
  logic [DW-1:0] INSTR;
  logic [AW-1:0] INSTR_PC;
  logic          INSTR_VALID;
  logic          INSTR_READY;
  logic          BR_TAKEN;
  logic [AW-1:0] BR_TARGET;
  logic          REDIRECT;
  logic [AW-1:0] REDIRECT_PC;
  logic          HALT_REQ;
  logic          HALTED;

  // Fetch controller side.
  modport master (
    output ABUS, INSTR, INSTR_PC, INSTR_VALID, HALTED,
    input  IM_DATA, INSTR_READY, BR_TAKEN, BR_TARGET,
           REDIRECT, REDIRECT_PC, HALT_REQ
  );

  // Memory and decode side.
  modport slave (
    input  ABUS, INSTR, INSTR_PC, INSTR_VALID, HALTED,
    output IM_DATA, INSTR_READY, BR_TAKEN, BR_TARGET,
           REDIRECT, REDIRECT_PC, HALT_REQ
  );

endinterface

// File: rtl/im_wait_timer.sv
// Loadable down-counter that stops at zero; zero flags the end of a wait.
module im_wait_timer #(
  parameter int             W         = 4,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  assign zero = (cnt == '0);

  // Count register: load wins over decrement, decrement saturates at zero.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!rst_n) begin
      cnt <= RESET_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/im_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, waits out the IM read delay,
// captures the byte and hands it to decode over valid/ready.
module im_fetch_ctrl
  import im_ctrl_pkg::*;
#(
  parameter int                      IM_ADDR_W_m1 = IM_ADDR_W - 1,
  parameter int                      IM_DATA_W_m1 = IM_DATA_W - 1,
  parameter int                      WAIT_CYCLES  = 2,
  parameter logic [IM_ADDR_W_m1:0]   RESET_PC     = '0
) (
  input  logic            CLK,
  input  logic            RST_N,
  im_fetch_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  fetch_state_e            state_q, state_d;
  logic [IM_ADDR_W_m1:0]   pc_q, pc_d;
  logic [IM_DATA_W_m1:0]   instr_q, instr_d;
  logic [IM_ADDR_W_m1:0]   instr_pc_q, instr_pc_d;
  logic                    valid_q, valid_d;
  logic                    halted_q, halted_d;
  logic                    tmr_load, tmr_dec, tmr_zero;
  logic                    consume;

  im_wait_timer #(
    .W         (CNT_W),
    .RESET_VAL (WAIT_LD)
  ) u_wait_timer (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (tmr_load),
    .load_val (WAIT_LD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  assign consume = valid_q && bus.INSTR_READY;

  // Next-state and next-register values; redirect overrides everything outside HALT.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;

    case (state_q)
      FETCH: begin
        if (bus.REDIRECT) begin
          pc_d     = bus.REDIRECT_PC;
          tmr_load = 1'b1;
          valid_d  = 1'b0;
        end else if (tmr_zero) begin
          instr_d    = bus.IM_DATA;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          state_d    = VALID;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      VALID: begin
        if (bus.REDIRECT) begin
          pc_d     = bus.REDIRECT_PC;
          tmr_load = 1'b1;
          valid_d  = 1'b0;
          state_d  = FETCH;
        end else if (consume) begin
          valid_d = 1'b0;
          if (bus.HALT_REQ) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            pc_d     = bus.BR_TAKEN ? bus.BR_TARGET : pc_q + 1'b1;
            tmr_load = 1'b1;
            state_d  = FETCH;
          end
        end
      end

      HALT: begin
        // Frozen until reset.
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State and output registers; reset discards any fetch or held instruction.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.ABUS        = pc_q;
  assign bus.INSTR       = instr_q;
  assign bus.INSTR_PC    = instr_pc_q;
  assign bus.INSTR_VALID = valid_q;
  assign bus.HALTED      = halted_q;

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Self-checking bench for im_fetch_ctrl: cycle table plus directed corner sequences.
module tb_im_fetch_ctrl;

  typedef struct {
    logic       rst_n;
    logic       ready;
    logic       chk_data;
    logic       valid;
    logic [7:0] instr;
    logic [7:0] ipc;
    logic [7:0] abus;
    logic       halted;
  } vec_t;

  logic clk;
  logic rst_n;
  logic [7:0] ram [256];
  vec_t vecs[$];
  int   checks;
  int   errors;

  im_fetch_ctrl_if bus ();

  im_fetch_ctrl dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  assign bus.IM_DATA = ram[bus.ABUS];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.INSTR_READY = 1'b0;
    bus.BR_TAKEN    = 1'b0;
    bus.BR_TARGET   = 8'h00;
    bus.REDIRECT    = 1'b0;
    bus.REDIRECT_PC = 8'h00;
    bus.HALT_REQ    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Steps until INSTR_VALID, returning the number of edges taken (bounded).
  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!bus.INSTR_VALID && n < 20) begin
      step();
      n++;
    end
    if (!bus.INSTR_VALID) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic redirect_to(input logic [7:0] addr);
    bus.REDIRECT    = 1'b1;
    bus.REDIRECT_PC = addr;
    step();
    bus.REDIRECT    = 1'b0;
  endtask

  task automatic consume(input logic br, input logic [7:0] tgt, input logic halt);
    bus.INSTR_READY = 1'b1;
    bus.BR_TAKEN    = br;
    bus.BR_TARGET   = tgt;
    bus.HALT_REQ    = halt;
    step();
    idle_inputs();
  endtask

  function automatic void add(input logic r, input logic rdy, input logic cd, input logic v,
                              input logic [7:0] ins, input logic [7:0] ipc,
                              input logic [7:0] ab, input logic h);
    vec_t t;
    t.rst_n = r; t.ready = rdy; t.chk_data = cd; t.valid = v;
    t.instr = ins; t.ipc = ipc; t.abus = ab; t.halted = h;
    vecs.push_back(t);
  endfunction

  initial begin
    logic [7:0] seq [4];
    int n;
    checks = 0;
    errors = 0;
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hA5;
    for (int i = 0; i < 4; i++) ram[i] = seq[i];

    // Sequential fetch with READY always high.
    add(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 0);
    add(1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0);
    add(1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0);
    add(1, 1, 1, 1, 8'h11, 8'h00, 8'h00, 0);
    for (int k = 1; k < 4; k++) begin
      for (int j = 0; j < 3; j++) add(1, 1, 0, 0, 8'h00, 8'h00, 8'(k), 0);
      add(1, 1, 1, 1, seq[k], 8'(k), 8'(k), 0);
    end
    // Back-pressure: instruction and address held while READY is low.
    add(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0);
    add(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
    add(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
    add(1, 0, 1, 1, 8'h11, 8'h00, 8'h00, 0);
    for (int j = 0; j < 10; j++) add(1, 0, 1, 1, 8'h11, 8'h00, 8'h00, 0);
    add(1, 1, 0, 0, 8'h00, 8'h00, 8'h01, 0);
    add(1, 0, 0, 0, 8'h00, 8'h00, 8'h01, 0);
    add(1, 0, 0, 0, 8'h00, 8'h00, 8'h01, 0);
    add(1, 0, 1, 1, 8'h22, 8'h01, 8'h01, 0);
    // Reset on the edge the wait counter reaches zero, then reset while VALID.
    add(1, 1, 0, 0, 8'h00, 8'h00, 8'h02, 0);
    add(1, 0, 0, 0, 8'h00, 8'h00, 8'h02, 0);
    add(1, 0, 0, 0, 8'h00, 8'h00, 8'h02, 0);
    add(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0);
    add(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
    add(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
    add(1, 0, 1, 1, 8'h11, 8'h00, 8'h00, 0);
    add(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0);

    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n           = vecs[i].rst_n;
      bus.INSTR_READY = vecs[i].ready;
      step();
      check($sformatf("vec%0d_valid", i), 32'(bus.INSTR_VALID), 32'(vecs[i].valid));
      check($sformatf("vec%0d_abus", i), 32'(bus.ABUS), 32'(vecs[i].abus));
      check($sformatf("vec%0d_halted", i), 32'(bus.HALTED), 32'(vecs[i].halted));
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d_instr", i), 32'(bus.INSTR), 32'(vecs[i].instr));
        check($sformatf("vec%0d_ipc", i), 32'(bus.INSTR_PC), 32'(vecs[i].ipc));
      end
    end

    // Taken branch to FE, then sequential wrap through FF to 00.
    do_reset();
    redirect_to(8'h05);
    wait_valid("br_w0", n);
    check("br_lat0", 32'(n), 32'd3);
    check("br_pc0", 32'(bus.INSTR_PC), 32'h05);
    check("br_ins0", 32'(bus.INSTR), 32'hA0);
    consume(1'b1, 8'hFE, 1'b0);
    check("br_abus", 32'(bus.ABUS), 32'hFE);
    check("br_vld_drop", 32'(bus.INSTR_VALID), 32'd0);
    wait_valid("br_w1", n);
    check("br_lat1", 32'(n), 32'd3);
    check("br_pc1", 32'(bus.INSTR_PC), 32'hFE);
    check("br_ins1", 32'(bus.INSTR), 32'h5B);
    consume(1'b0, 8'h00, 1'b0);
    check("seq_abus_ff", 32'(bus.ABUS), 32'hFF);
    wait_valid("br_w2", n);
    check("seq_pc_ff", 32'(bus.INSTR_PC), 32'hFF);
    check("seq_ins_ff", 32'(bus.INSTR), 32'h5A);
    consume(1'b0, 8'h00, 1'b0);
    check("wrap_abus", 32'(bus.ABUS), 32'h00);
    wait_valid("br_w3", n);
    check("wrap_pc", 32'(bus.INSTR_PC), 32'h00);
    check("wrap_ins", 32'(bus.INSTR), 32'h11);

    // Redirect aborts a fetch in progress and outranks a consuming branch.
    do_reset();
    step();
    redirect_to(8'h40);
    check("rd_vld0", 32'(bus.INSTR_VALID), 32'd0);
    check("rd_abus0", 32'(bus.ABUS), 32'h40);
    wait_valid("rd_w0", n);
    check("rd_lat0", 32'(n), 32'd3);
    check("rd_pc0", 32'(bus.INSTR_PC), 32'h40);
    check("rd_ins0", 32'(bus.INSTR), 32'hE5);
    bus.REDIRECT    = 1'b1;
    bus.REDIRECT_PC = 8'h40;
    consume(1'b1, 8'hFE, 1'b0);
    check("rd_vld1", 32'(bus.INSTR_VALID), 32'd0);
    check("rd_abus1", 32'(bus.ABUS), 32'h40);
    wait_valid("rd_w1", n);
    check("rd_lat1", 32'(n), 32'd3);
    check("rd_pc1", 32'(bus.INSTR_PC), 32'h40);
    // Held redirect restarts each cycle; completion counts from the last one.
    bus.REDIRECT    = 1'b1;
    bus.REDIRECT_PC = 8'h07;
    for (int j = 0; j < 3; j++) begin
      step();
      check($sformatf("rd_hold%0d_vld", j), 32'(bus.INSTR_VALID), 32'd0);
    end
    bus.REDIRECT = 1'b0;
    wait_valid("rd_w2", n);
    check("rd_lat2", 32'(n), 32'd3);
    check("rd_pc2", 32'(bus.INSTR_PC), 32'h07);
    check("rd_ins2", 32'(bus.INSTR), 32'hA2);

    // Halt outranks branch; HALT ignores redirects until reset.
    do_reset();
    redirect_to(8'h05);
    wait_valid("h_w0", n);
    check("h_pc0", 32'(bus.INSTR_PC), 32'h05);
    consume(1'b1, 8'hFE, 1'b1);
    check("h_halted", 32'(bus.HALTED), 32'd1);
    check("h_vld", 32'(bus.INSTR_VALID), 32'd0);
    check("h_abus", 32'(bus.ABUS), 32'h05);
    for (int j = 0; j < 20; j++) begin
      bus.INSTR_READY = 1'b1;
      bus.BR_TAKEN    = 1'b1;
      bus.BR_TARGET   = 8'hFE;
      bus.REDIRECT    = j[0];
      bus.REDIRECT_PC = 8'h40;
      step();
      check($sformatf("h_frz%0d_abus", j), 32'(bus.ABUS), 32'h05);
      check($sformatf("h_frz%0d_halted", j), 32'(bus.HALTED), 32'd1);
      check($sformatf("h_frz%0d_vld", j), 32'(bus.INSTR_VALID), 32'd0);
    end
    check("h_frz_ins", 32'(bus.INSTR), 32'hA0);
    check("h_frz_ipc", 32'(bus.INSTR_PC), 32'h05);
    do_reset();
    check("h_rst_halted", 32'(bus.HALTED), 32'd0);
    check("h_rst_abus", 32'(bus.ABUS), 32'h00);
    check("h_rst_vld", 32'(bus.INSTR_VALID), 32'd0);
    wait_valid("h_w1", n);
    check("h_rst_lat", 32'(n), 32'd3);
    check("h_rst_pc", 32'(bus.INSTR_PC), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
